// File: rtl/pic_pkg.sv
// Shared types and bit positions for the 8259A-compatible controller write path.
package pic_pkg;

    typedef enum logic [2:0] {
        StUninit,
        StWaitIcw2,
        StWaitIcw3,
        StWaitIcw4,
        StReady
    } seq_state_e;

    typedef enum logic [1:0] {
        CmdIcw1,
        CmdA0Write,
        CmdOcw2,
        CmdOcw3
    } cmd_class_e;

    localparam int unsigned ICW1_IC4     = 0;
    localparam int unsigned ICW1_SNGL    = 1;
    localparam int unsigned ICW1_LTIM    = 3;
    localparam int unsigned CMD_D3       = 3;
    localparam int unsigned CMD_D4       = 4;
    localparam int unsigned ICW4_UPM     = 0;
    localparam int unsigned ICW4_AEOI    = 1;
    localparam int unsigned ICW4_MS      = 2;
    localparam int unsigned ICW4_BUF     = 3;
    localparam int unsigned ICW4_SFNM    = 4;

endpackage

// File: rtl/command_word_decoder.sv
// Combinational classification of a CPU write (A0 + data byte) into a command class.
module command_word_decoder
    import pic_pkg::*;
(
    input  logic       a0,
    input  logic [7:0] data_in,
    output cmd_class_e cmd_class
);

    // Only D4/D3 take part in classification; the rest is payload.
    logic unused_data;
    assign unused_data = ^{data_in[7:5], data_in[2:0]};

    always_comb begin
        cmd_class = CmdA0Write;
        if (!a0) begin
            if (data_in[CMD_D4]) begin
                cmd_class = CmdIcw1;
            end else if (data_in[CMD_D3]) begin
                cmd_class = CmdOcw3;
            end else begin
                cmd_class = CmdOcw2;
            end
        end
    end

endmodule

// File: rtl/command_word_sequencer.sv
// Tracks the ICW1..ICW4 init sequence, classifies later writes as OCWs and emits
// registered one-cycle strobes with the data byte aligned to them.
module command_word_sequencer
    import pic_pkg::*;
#(
    parameter bit SEQ_ERROR_EN = 1'b1
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       wr_pulse,
    input  logic       a0,
    input  logic [7:0] data_in,
    output logic [7:0] internal_data_bus,
    output logic       ICW_1,
    output logic       ICW_2_4,
    output logic       OCW_1,
    output logic       OCW_2,
    output logic       OCW_3,
    output logic       ltim,
    output logic       sngl,
    output logic       ic4,
    output logic [4:0] vector_base,
    output logic [7:0] cascade_config,
    output logic       aeoi,
    output logic       buf_mode,
    output logic       master_slave,
    output logic       sfnm,
    output logic       upm,
    output logic       init_done,
    output logic       seq_error
);

    cmd_class_e cmd_class;
    seq_state_e state_q;

    command_word_decoder u_decoder (
        .a0        (a0),
        .data_in   (data_in),
        .cmd_class (cmd_class)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q           <= StUninit;
            internal_data_bus <= 8'h00;
            ICW_1             <= 1'b0;
            ICW_2_4           <= 1'b0;
            OCW_1             <= 1'b0;
            OCW_2             <= 1'b0;
            OCW_3             <= 1'b0;
            seq_error         <= 1'b0;
            ltim              <= 1'b0;
            sngl              <= 1'b0;
            ic4               <= 1'b0;
            vector_base       <= 5'h00;
            cascade_config    <= 8'h00;
            aeoi              <= 1'b0;
            buf_mode          <= 1'b0;
            master_slave      <= 1'b0;
            sfnm              <= 1'b0;
            upm               <= 1'b0;
            init_done         <= 1'b0;
        end else begin
            ICW_1     <= 1'b0;
            ICW_2_4   <= 1'b0;
            OCW_1     <= 1'b0;
            OCW_2     <= 1'b0;
            OCW_3     <= 1'b0;
            seq_error <= 1'b0;
            if (wr_pulse) begin
                if (cmd_class == CmdIcw1) begin
                    // ICW1 restarts from any state; vector_base survives until the next ICW2.
                    state_q           <= StWaitIcw2;
                    internal_data_bus <= data_in;
                    ICW_1             <= 1'b1;
                    ltim              <= data_in[ICW1_LTIM];
                    sngl              <= data_in[ICW1_SNGL];
                    ic4               <= data_in[ICW1_IC4];
                    cascade_config    <= 8'h00;
                    aeoi              <= 1'b0;
                    buf_mode          <= 1'b0;
                    master_slave      <= 1'b0;
                    sfnm              <= 1'b0;
                    upm               <= 1'b0;
                    init_done         <= 1'b0;
                end else begin
                    unique case (state_q)
                        StUninit: begin
                            seq_error <= SEQ_ERROR_EN;
                        end
                        StWaitIcw2: begin
                            if (cmd_class == CmdA0Write) begin
                                internal_data_bus <= data_in;
                                ICW_2_4           <= 1'b1;
                                vector_base       <= data_in[7:3];
                                if (!sngl) begin
                                    state_q <= StWaitIcw3;
                                end else if (ic4) begin
                                    state_q <= StWaitIcw4;
                                end else begin
                                    state_q   <= StReady;
                                    init_done <= 1'b1;
                                end
                            end else begin
                                seq_error <= SEQ_ERROR_EN;
                            end
                        end
                        StWaitIcw3: begin
                            if (cmd_class == CmdA0Write) begin
                                internal_data_bus <= data_in;
                                ICW_2_4           <= 1'b1;
                                cascade_config    <= data_in;
                                if (ic4) begin
                                    state_q <= StWaitIcw4;
                                end else begin
                                    state_q   <= StReady;
                                    init_done <= 1'b1;
                                end
                            end else begin
                                seq_error <= SEQ_ERROR_EN;
                            end
                        end
                        StWaitIcw4: begin
                            if (cmd_class == CmdA0Write) begin
                                internal_data_bus <= data_in;
                                ICW_2_4           <= 1'b1;
                                upm               <= data_in[ICW4_UPM];
                                aeoi              <= data_in[ICW4_AEOI];
                                master_slave      <= data_in[ICW4_MS];
                                buf_mode          <= data_in[ICW4_BUF];
                                sfnm              <= data_in[ICW4_SFNM];
                                state_q           <= StReady;
                                init_done         <= 1'b1;
                            end else begin
                                seq_error <= SEQ_ERROR_EN;
                            end
                        end
                        StReady: begin
                            internal_data_bus <= data_in;
                            OCW_1 <= (cmd_class == CmdA0Write);
                            OCW_2 <= (cmd_class == CmdOcw2);
                            OCW_3 <= (cmd_class == CmdOcw3);
                        end
                        default: begin
                            state_q <= StUninit;
                        end
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_command_word_sequencer.sv
// Directed self-checking bench for command_word_sequencer.
module tb_command_word_sequencer;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       wr_pulse = 1'b0;
    logic       a0 = 1'b0;
    logic [7:0] data_in = 8'h00;

    logic [7:0] internal_data_bus, cascade_config;
    logic [4:0] vector_base;
    logic ICW_1, ICW_2_4, OCW_1, OCW_2, OCW_3, ltim, sngl, ic4;
    logic aeoi, buf_mode, master_slave, sfnm, upm, init_done, seq_error;

    logic [7:0] ne_bus, ne_cas;
    logic [4:0] ne_vb;
    logic ne_i1, ne_i24, ne_o1, ne_o2, ne_o3, ne_ltim, ne_sngl, ne_ic4;
    logic ne_aeoi, ne_buf, ne_ms, ne_sfnm, ne_upm, ne_done, ne_err;

    int n_checks = 0;
    int n_pass = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    command_word_sequencer #(.SEQ_ERROR_EN(1'b1)) u_dut (
        .clk(clk), .reset_n(reset_n), .wr_pulse(wr_pulse), .a0(a0), .data_in(data_in),
        .internal_data_bus(internal_data_bus), .ICW_1(ICW_1), .ICW_2_4(ICW_2_4),
        .OCW_1(OCW_1), .OCW_2(OCW_2), .OCW_3(OCW_3), .ltim(ltim), .sngl(sngl), .ic4(ic4),
        .vector_base(vector_base), .cascade_config(cascade_config), .aeoi(aeoi),
        .buf_mode(buf_mode), .master_slave(master_slave), .sfnm(sfnm), .upm(upm),
        .init_done(init_done), .seq_error(seq_error)
    );

    command_word_sequencer #(.SEQ_ERROR_EN(1'b0)) u_dut_noerr (
        .clk(clk), .reset_n(reset_n), .wr_pulse(wr_pulse), .a0(a0), .data_in(data_in),
        .internal_data_bus(ne_bus), .ICW_1(ne_i1), .ICW_2_4(ne_i24),
        .OCW_1(ne_o1), .OCW_2(ne_o2), .OCW_3(ne_o3), .ltim(ne_ltim), .sngl(ne_sngl),
        .ic4(ne_ic4), .vector_base(ne_vb), .cascade_config(ne_cas), .aeoi(ne_aeoi),
        .buf_mode(ne_buf), .master_slave(ne_ms), .sfnm(ne_sfnm), .upm(ne_upm),
        .init_done(ne_done), .seq_error(ne_err)
    );

    // {ICW_1, ICW_2_4, OCW_1, OCW_2, OCW_3, seq_error}
    function automatic logic [5:0] strobes();
        return {ICW_1, ICW_2_4, OCW_1, OCW_2, OCW_3, seq_error};
    endfunction

    function automatic logic [35:0] all_outputs();
        return {internal_data_bus, ICW_1, ICW_2_4, OCW_1, OCW_2, OCW_3, seq_error,
                ltim, sngl, ic4, vector_base, cascade_config,
                aeoi, buf_mode, master_slave, sfnm, upm, init_done};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Present a write for one cycle; returns at the next negedge with its results visible.
    task automatic drive(input logic a, input logic [7:0] d);
        wr_pulse = 1'b1;
        a0       = a;
        data_in  = d;
        @(negedge clk);
    endtask

    task automatic idle();
        wr_pulse = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        #12;
        reset_n = 1'b1;
        @(negedge clk);
        check("reset_outputs", 64'(all_outputs()), 64'h0);

        // Illegal write in UNINIT
        drive(1'b0, 8'h20);
        check("uninit_err_strobes", 64'(strobes()), 64'b000001);
        check("uninit_err_bus", 64'(internal_data_bus), 64'h00);
        check("uninit_noerr_inst", 64'(ne_err), 64'h0);
        idle();
        check("uninit_err_one_cycle", 64'(strobes()), 64'h0);

        // Single, with ICW4, back-to-back
        drive(1'b0, 8'h13);
        check("s_icw1_strobe", 64'(strobes()), 64'b100000);
        check("s_icw1_cfg", 64'({ltim, sngl, ic4}), 64'b011);
        drive(1'b1, 8'h20);
        check("s_icw2_strobe", 64'(strobes()), 64'b010000);
        check("s_icw2_vb", 64'(vector_base), 64'h04);
        check("s_icw2_not_done", 64'(init_done), 64'h0);
        drive(1'b1, 8'h03);
        check("s_icw4_strobe", 64'(strobes()), 64'b010000);
        check("s_icw4_fields", 64'({aeoi, buf_mode, master_slave, sfnm, upm}), 64'b10001);
        check("s_done", 64'(init_done), 64'h1);
        check("s_cascade", 64'(cascade_config), 64'h00);
        check("s_bus", 64'(internal_data_bus), 64'h03);
        idle();
        check("s_idle_strobes", 64'(strobes()), 64'h0);

        // OCWs in READY
        drive(1'b1, 8'hF0);
        check("ocw1_strobe", 64'(strobes()), 64'b001000);
        check("ocw1_bus", 64'(internal_data_bus), 64'hF0);
        idle();
        check("ocw1_one_cycle", 64'(strobes()), 64'h0);
        check("ocw1_bus_hold", 64'(internal_data_bus), 64'hF0);
        drive(1'b0, 8'h20);
        check("ocw2_strobe", 64'(strobes()), 64'b000100);
        check("ocw2_bus", 64'(internal_data_bus), 64'h20);
        idle();
        check("ocw2_one_cycle", 64'(strobes()), 64'h0);
        drive(1'b0, 8'h0B);
        check("ocw3_strobe", 64'(strobes()), 64'b000010);
        check("ocw3_bus", 64'(internal_data_bus), 64'h0B);
        idle();
        check("ocw3_one_cycle", 64'(strobes()), 64'h0);

        // Cascade sequence, restarts from READY
        drive(1'b0, 8'h11);
        check("c_icw1_strobe", 64'(strobes()), 64'b100000);
        check("c_icw1_clears", 64'({aeoi, upm, init_done}), 64'b000);
        check("c_icw1_cfg", 64'({sngl, ic4}), 64'b01);
        drive(1'b1, 8'h08);
        check("c_icw2_strobe", 64'(strobes()), 64'b010000);
        check("c_icw2_vb", 64'(vector_base), 64'h01);
        drive(1'b1, 8'h04);
        check("c_icw3_strobe", 64'(strobes()), 64'b010000);
        check("c_icw3_cascade", 64'(cascade_config), 64'h04);
        check("c_icw3_not_done", 64'(init_done), 64'h0);
        drive(1'b1, 8'h01);
        check("c_icw4_strobe", 64'(strobes()), 64'b010000);
        check("c_icw4_fields", 64'({aeoi, upm, init_done}), 64'b011);
        idle();

        // Illegal write while waiting for ICW3
        drive(1'b0, 8'h10);
        drive(1'b1, 8'hF8);
        check("w3_vb", 64'(vector_base), 64'h1F);
        drive(1'b0, 8'h08);
        check("w3_err_strobes", 64'(strobes()), 64'b000001);
        check("w3_err_bus_hold", 64'(internal_data_bus), 64'hF8);
        check("w3_noerr_inst", 64'({ne_err, ne_i24}), 64'b00);
        drive(1'b1, 8'h55);
        check("w3_icw3_after_err", 64'(strobes()), 64'b010000);
        check("w3_cascade_done", 64'({cascade_config, init_done}), 64'h0AB);
        idle();

        // ICW1 mid-READY restart
        drive(1'b0, 8'h12);
        drive(1'b1, 8'hA8);
        check("r_ready", 64'({vector_base, init_done}), 64'b101011);
        drive(1'b0, 8'h11);
        check("r_icw1_strobe", 64'(strobes()), 64'b100000);
        check("r_icw1_state", 64'({init_done, aeoi, buf_mode, master_slave, sfnm, upm}), 64'h0);
        check("r_vb_kept", 64'(vector_base), 64'h15);
        drive(1'b1, 8'hC0);
        check("r_a0_is_icw2", 64'(strobes()), 64'b010000);
        check("r_vb_new", 64'(vector_base), 64'h18);
        idle();

        // Reset mid-sequence
        drive(1'b0, 8'h13);
        drive(1'b1, 8'h20);
        idle();
        check("rst_pre_strobe", 64'(strobes()), 64'h0);
        drive(1'b0, 8'h13);
        drive(1'b1, 8'h28);
        check("rst_inflight", 64'(ICW_2_4), 64'h1);
        wr_pulse = 1'b0;
        #1;
        reset_n = 1'b0;
        #1;
        check("rst_async_clear", 64'(all_outputs()), 64'h0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        drive(1'b1, 8'h33);
        check("rst_then_a0_err", 64'(strobes()), 64'b000001);
        check("rst_then_bus", 64'(internal_data_bus), 64'h00);
        idle();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: observed running expected finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/command_word_sequencer.md
# command_word_sequencer

Write-path front end of the 8259A-compatible interrupt controller: accepts CPU register writes (A0 plus data byte), tracks the ICW1→ICW2→[ICW3]→[ICW4] initialization sequence and classifies later writes as OCW1/2/3. Emits one-cycle strobes and a registered data byte aligned to them, feeding `Control_Logic` (`ICW_1`, `ICW_2_4`, `OCW_1..3`, `internal_data_bus`). Holds decoded init configuration for the rest of the controller.

## Interface
- `SEQ_ERROR_EN`, 1: enables the `seq_error` pulse; when 0, `seq_error` is tied 0.
- `clk` input 1: system clock, all state on rising edge.
- `reset_n` input 1: asynchronous, active-low reset.
- `wr_pulse` input 1: one-cycle write qualifier, already edge-detected upstream.
- `a0` input 1: register address bit.
- `data_in` input 8: CPU write data, valid with `wr_pulse`.
- `internal_data_bus` output 8: registered copy of `data_in`, valid with any strobe.
- `ICW_1`, `ICW_2_4`, `OCW_1`, `OCW_2`, `OCW_3` output 1 each: one-cycle strobes.
- `ltim`, `sngl`, `ic4` output 1 each: ICW1 D3, D1, D0.
- `vector_base` output 5: ICW2 D7:D3.
- `cascade_config` output 8: ICW3 byte.
- `aeoi`, `buf_mode`, `master_slave`, `sfnm`, `upm` output 1 each: ICW4 D1, D3, D2, D4, D0.
- `init_done` output 1: high once the sequence completes.
- `seq_error` output 1: one-cycle pulse on an illegal write.

## Operation
- FSM states: `UNINIT`, `WAIT_ICW2`, `WAIT_ICW3`, `WAIT_ICW4`, `READY`.
- Classification, any state, with `wr_pulse`: `a0=0` and D4=1 is ICW1. It always wins, restarts the sequence and goes to `WAIT_ICW2`.
- ICW1 effects:
  - latch `ltim/sngl/ic4`;
  - clear `aeoi`, `buf_mode`, `master_slave`, `sfnm`, `upm`;
  - clear `cascade_config`;
  - `init_done`←0;
  - `ICW_1` pulse.
- `WAIT_ICW2`, `a0=1`: latch `vector_base`, pulse `ICW_2_4`. Next state is `WAIT_ICW3` if `sngl=0`, else `WAIT_ICW4` if `ic4=1`, else `READY`.
- `WAIT_ICW3`, `a0=1`: latch `cascade_config`, pulse `ICW_2_4`. Next state is `WAIT_ICW4` if `ic4`, else `READY`.
- `WAIT_ICW4`, `a0=1`: latch ICW4 fields, pulse `ICW_2_4`, go to `READY`.
- Entering `READY` sets `init_done`=1.
- `READY`:
  - `a0=1` pulses `OCW_1`;
  - `a0=0`, D4=0, D3=0 pulses `OCW_2`;
  - `a0=0`, D4=0, D3=1 pulses `OCW_3`.
- Illegal writes pulse `seq_error` and change no state or strobe:
  - in `UNINIT`, anything other than ICW1;
  - in `WAIT_ICW2/3/4`, `a0=0` with D4=0.
- At most one strobe is high in any cycle.

## Timing
- Reset (async, `reset_n`=0): state `UNINIT`. All strobes, `seq_error`, `init_done` and every config output are 0, and `internal_data_bus`=8'h00.
- Latency is 1 cycle: a write sampled at edge N drives its strobe, `internal_data_bus` and config updates high during cycle N+1.
- `internal_data_bus` updates only on accepted writes and holds between writes.
- Back-to-back `wr_pulse` in consecutive cycles is fully supported, so a full ICW1..ICW4 sequence completes in 4 cycles.
- ICW1 arriving mid-sequence or in `READY` immediately restarts the sequence. No partial-state leakage: the old `vector_base` stays until the new ICW2.
- Reset asserted mid-sequence forces `UNINIT` asynchronously. A strobe in flight is cleared.

## Structure
- `pic_pkg` holds:
  - the state enum encoding;
  - bit-position constants (`ICW1_IC4`=0, `ICW1_SNGL`=1, `ICW1_LTIM`=3, `CMD_D3`=3, `CMD_D4`=4, ICW4 field bits);
  - a command-class enum (ICW1, A0_WRITE, OCW2, OCW3).
- One combinational sub-module `command_word_decoder` maps (`a0`, `data_in`) to the command class. The FSM and registers stay in `command_word_sequencer`.

## Test plan
- Reset then writes ICW1=8'h13 (`sngl`=1, `ic4`=1), ICW2=8'h20, ICW4=8'h03 → `ICW_1`, `ICW_2_4`, `ICW_2_4` pulses. Expect `vector_base`=5'h04, `aeoi`=1, `upm`=1, `init_done`=1 after the third strobe, and `cascade_config`=0.
- Cascade: ICW1=8'h11, ICW2=8'h08, ICW3=8'h04, ICW4=8'h01 → three `ICW_2_4` pulses, `cascade_config`=8'h04, `init_done` after the 4th write.
- In `READY`: `a0=1`/8'hF0 → `OCW_1` with bus F0; `a0=0`/8'h20 → `OCW_2`; `a0=0`/8'h0B → `OCW_3`. Each strobe exactly one cycle, one cycle after `wr_pulse`.
- ICW1=8'h12 (`sngl`=1, `ic4`=0), ICW2 → `READY`. Then a new ICW1=8'h11 mid-`READY` → `init_done`=0, ICW4 fields cleared, state `WAIT_ICW2`.
- Illegal writes:
  - `a0=0`/8'h20 in `UNINIT` → `seq_error` pulse, no strobe;
  - `a0=0`/8'h08 in `WAIT_ICW3` → `seq_error`, state unchanged;
  - with `SEQ_ERROR_EN`=0, same stimulus → `seq_error` stays 0.
- Drop `reset_n` in the cycle after the ICW2 write (`ICW_2_4` high) → all outputs 0 immediately. After release the next write `a0=1` yields `seq_error`.
